// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg -- shared CPU datapath types.
//   word_t    : 32-bit machine word (PCs, targets).
//   btb_ctr_t : 2-bit branch-direction counter state; bit 1 set means "predict taken".
//   ctr_taken : helper returning the direction a counter state predicts.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } btb_ctr_t;

   function automatic logic ctr_taken(input btb_ctr_t c);
      return c[1];
   endfunction

endpackage

// File: rtl/sat_counter2.sv
// sat_counter2 -- next-state logic of a 2-bit saturating direction counter.
//   cur   in  current counter state
//   taken in  resolved branch outcome (1 = count up, 0 = count down)
//   next  out updated state, saturating at STRONG_T / STRONG_NT
module sat_counter2
   import cpu_types_pkg::*;
(
   input  btb_ctr_t cur,
   input  logic     taken,
   output btb_ctr_t next
);

   always_comb begin
      next = cur;
      unique case (cur)
         STRONG_NT: next = taken ? WEAK_NT  : STRONG_NT;
         WEAK_NT:   next = taken ? WEAK_T   : STRONG_NT;
         WEAK_T:    next = taken ? STRONG_T : WEAK_NT;
         STRONG_T:  next = taken ? STRONG_T : WEAK_T;
         default:   next = cur;
      endcase
   end

endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer -- direct-mapped BTB with 2-bit direction counters.
// Lookup is purely combinational from registered state; the memory-stage
// update writes on the rising edge, so a same-cycle lookup sees old contents.
//
// Ports:
//   CLK            clock
//   nRST           synchronous active-high reset (clears everything, ignores en)
//   en             pipeline enable; gates every state update
//   inv            invalidate all entries (wins over a simultaneous update)
//   lookup_pc      fetch-stage PC
//   pred_hit       valid entry with matching tag
//   pred_taken     hit and counter predicts taken
//   pred_target    stored target when predicted taken, else lookup_pc + 4
//   upd_valid      resolved branch present in memory stage
//   upd_pc         PC of the resolved branch
//   upd_taken      actual outcome
//   upd_target     actual branch address
//   upd_mispredict prediction carried with the branch was wrong
//   stat_lookups / stat_mispredicts  (only with BTB_STATS_EN) saturating counters
//
// Optional feature macro: BTB_STATS_EN adds the two statistics counters/ports.
module branch_target_buffer
   import cpu_types_pkg::*;
#(
   parameter int       ENTRIES   = 16,
   parameter btb_ctr_t ALLOC_CTR = WEAK_T
) (
   input  logic  CLK,
   input  logic  nRST,
   input  logic  en,
   input  logic  inv,
   input  word_t lookup_pc,
   output logic  pred_hit,
   output logic  pred_taken,
   output word_t pred_target,
   input  logic  upd_valid,
   input  word_t upd_pc,
   input  logic  upd_taken,
   input  word_t upd_target,
   input  logic  upd_mispredict
`ifdef BTB_STATS_EN
   ,
   output word_t stat_lookups,
   output word_t stat_mispredicts
`endif
);

   localparam int IDX   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam int TAG_W = 32 - IDX - 2;

   if ((ENTRIES < 2) || (ENTRIES > 256) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_bad_entries
      $error("branch_target_buffer: ENTRIES must be a power of two in 2..256");
   end

   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   word_t              target_q [ENTRIES];
   btb_ctr_t           ctr_q    [ENTRIES];

   // Lookup path
   logic [IDX-1:0]   lidx;
   logic [TAG_W-1:0] ltag;

   assign lidx = lookup_pc[IDX+1:2];
   assign ltag = lookup_pc[31:IDX+2];

   // Gated with reset so the outputs are clean while state is being cleared.
   assign pred_hit    = !nRST && valid_q[lidx] && (tag_q[lidx] == ltag);
   assign pred_taken  = pred_hit && ctr_taken(ctr_q[lidx]);
   assign pred_target = pred_taken ? target_q[lidx] : (lookup_pc + 32'd4);

   // Update path
   logic [IDX-1:0]   uidx;
   logic [TAG_W-1:0] utag;
   logic             uhit;
   btb_ctr_t         ctr_next;

   assign uidx = upd_pc[IDX+1:2];
   assign utag = upd_pc[31:IDX+2];
   assign uhit = valid_q[uidx] && (tag_q[uidx] == utag);

   sat_counter2 u_ctr (
      .cur   (ctr_q[uidx]),
      .taken (upd_taken),
      .next  (ctr_next)
   );

   always_ff @(posedge CLK) begin
      if (nRST) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= WEAK_NT;
         end
      end else if (en) begin
         if (inv) begin
            valid_q <= '0;
         end else if (upd_valid) begin
            if (uhit) begin
               ctr_q[uidx] <= ctr_next;
               if (upd_taken) target_q[uidx] <= upd_target;
            end else if (upd_taken) begin
               // Miss with taken outcome: allocate, evicting whatever lives here.
               valid_q[uidx]  <= 1'b1;
               tag_q[uidx]    <= utag;
               target_q[uidx] <= upd_target;
               ctr_q[uidx]    <= ALLOC_CTR;
            end
         end
      end
   end

`ifdef BTB_STATS_EN
   word_t lookups_q, mispredicts_q;

   always_ff @(posedge CLK) begin
      if (nRST) begin
         lookups_q     <= '0;
         mispredicts_q <= '0;
      end else if (en) begin
         if (lookups_q != 32'hFFFF_FFFF) lookups_q <= lookups_q + 32'd1;
         if (upd_valid && upd_mispredict && (mispredicts_q != 32'hFFFF_FFFF))
            mispredicts_q <= mispredicts_q + 32'd1;
      end
   end

   assign stat_lookups     = lookups_q;
   assign stat_mispredicts = mispredicts_q;
`endif

   // Word-offset PC bits never address the table; the mispredict flag only
   // matters when statistics are built in.
   logic unused_bits;
   assign unused_bits = ^{upd_mispredict, lookup_pc[1:0], upd_pc[1:0]};

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;
   import cpu_types_pkg::*;

   logic  CLK = 1'b0;
   logic  nRST, en, inv, upd_valid, upd_taken, upd_mispredict;
   word_t lookup_pc, upd_pc, upd_target, pred_target;
   logic  pred_hit, pred_taken;
`ifdef BTB_STATS_EN
   word_t stat_lookups, stat_mispredicts;
`endif

   int n_cmp = 0;
   int n_err = 0;

   branch_target_buffer #(.ENTRIES(16), .ALLOC_CTR(WEAK_T)) dut (
      .CLK            (CLK),
      .nRST           (nRST),
      .en             (en),
      .inv            (inv),
      .lookup_pc      (lookup_pc),
      .pred_hit       (pred_hit),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .upd_valid      (upd_valid),
      .upd_pc         (upd_pc),
      .upd_taken      (upd_taken),
      .upd_target     (upd_target),
      .upd_mispredict (upd_mispredict)
`ifdef BTB_STATS_EN
      ,
      .stat_lookups     (stat_lookups),
      .stat_mispredicts (stat_mispredicts)
`endif
   );

   always #5 CLK = ~CLK;

   // Advance one clock; inputs change 1 ns after the rising edge.
   task automatic cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      upd_valid = 1'b0; upd_taken = 1'b0; upd_mispredict = 1'b0;
      inv = 1'b0; en = 1'b1;
   endtask

   task automatic upd(input word_t pc, input logic tk, input word_t tgt);
      upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
      cycle();
      idle();
   endtask

   task automatic test_reset();
      nRST = 1'b1; en = 1'b1; inv = 1'b0; upd_mispredict = 1'b0;
      lookup_pc = 32'h40;
      upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h80;
      #1;
      n_cmp++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL rst_hit_during: got %b want 0", pred_hit); end
      n_cmp++; if (pred_target !== 32'h44) begin n_err++; $display("FAIL rst_target_during: got %h want 00000044", pred_target); end
      cycle(); cycle();
      nRST = 1'b0; idle();
      #1;
      n_cmp++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL rst_hit_after: got %b want 0", pred_hit); end
      n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL rst_taken_after: got %b want 0", pred_taken); end
      n_cmp++; if (pred_target !== 32'h44) begin n_err++; $display("FAIL rst_target_after: got %h want 00000044", pred_target); end
   endtask

   task automatic test_alloc();
      lookup_pc = 32'h40;
      upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h80;
      #1;
      n_cmp++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL alloc_same_cycle_hit: got %b want 0", pred_hit); end
      cycle(); idle(); #1;
      n_cmp++; if (pred_hit !== 1'b1) begin n_err++; $display("FAIL alloc_hit: got %b want 1", pred_hit); end
      n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL alloc_taken: got %b want 1", pred_taken); end
      n_cmp++; if (pred_target !== 32'h80) begin n_err++; $display("FAIL alloc_target: got %h want 00000080", pred_target); end
   endtask

   // Entry at 0x40 starts at WEAK_T with target 0x80.
   task automatic test_counter();
      lookup_pc = 32'h40;
      upd(32'h40, 1'b0, 32'hBAD0); #1;   // 10 -> 01
      n_cmp++; if (pred_hit !== 1'b1) begin n_err++; $display("FAIL ctr1_hit: got %b want 1", pred_hit); end
      n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL ctr1_taken: got %b want 0", pred_taken); end
      upd(32'h40, 1'b0, 32'hBAD0);       // 01 -> 00
      upd(32'h40, 1'b0, 32'hBAD0); #1;   // 00 -> 00
      n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL ctr3_taken: got %b want 0", pred_taken); end
      n_cmp++; if (pred_target !== 32'h44) begin n_err++; $display("FAIL ctr3_target: got %h want 00000044", pred_target); end
      upd(32'h40, 1'b1, 32'h88); #1;     // 00 -> 01 (wrap would read taken)
      n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL ctr_sat_low: got %b want 0", pred_taken); end
      upd(32'h40, 1'b1, 32'h88); #1;     // 01 -> 10
      n_cmp++; if (pred_target !== 32'h88) begin n_err++; $display("FAIL ctr_up_target: got %h want 00000088", pred_target); end
      upd(32'h40, 1'b1, 32'h8C);         // 10 -> 11
      upd(32'h40, 1'b1, 32'h8C);         // 11 -> 11
      upd(32'h40, 1'b0, 32'hBAD0); #1;   // 11 -> 10, target kept
      n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL ctr_sat_high: got %b want 1", pred_taken); end
      n_cmp++; if (pred_target !== 32'h8C) begin n_err++; $display("FAIL nt_keeps_target: got %h want 0000008c", pred_target); end
   endtask

   task automatic test_miss_not_taken();
      lookup_pc = 32'h48;
      upd(32'h48, 1'b0, 32'h200); #1;
      n_cmp++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL miss_nt_no_alloc: got %b want 0", pred_hit); end
   endtask

   task automatic test_conflict();
      upd(32'h80, 1'b1, 32'h200);
      lookup_pc = 32'h40; #1;
      n_cmp++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL conflict_old_hit: got %b want 0", pred_hit); end
      lookup_pc = 32'h80; #1;
      n_cmp++; if (pred_hit !== 1'b1) begin n_err++; $display("FAIL conflict_new_hit: got %b want 1", pred_hit); end
      n_cmp++; if (pred_target !== 32'h200) begin n_err++; $display("FAIL conflict_new_target: got %h want 00000200", pred_target); end
   endtask

   task automatic test_hold_en();
      en = 1'b0; inv = 1'b1;
      upd_valid = 1'b1; upd_pc = 32'h50; upd_taken = 1'b1; upd_target = 32'h300;
      cycle(); cycle();
      en = 1'b0; inv = 1'b0; upd_valid = 1'b0;
      lookup_pc = 32'h80; #1;
      n_cmp++; if (pred_hit !== 1'b1) begin n_err++; $display("FAIL hold_keeps_entry: got %b want 1", pred_hit); end
      lookup_pc = 32'h50; #1;
      n_cmp++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL hold_no_alloc: got %b want 0", pred_hit); end
      idle();
   endtask

   task automatic test_inv();
      inv = 1'b1;
      upd_valid = 1'b1; upd_pc = 32'h60; upd_taken = 1'b1; upd_target = 32'h400;
      cycle(); idle();
      lookup_pc = 32'h80; #1;
      n_cmp++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL inv_clears: got %b want 0", pred_hit); end
      lookup_pc = 32'h60; #1;
      n_cmp++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL inv_drops_update: got %b want 0", pred_hit); end
   endtask

`ifdef BTB_STATS_EN
   task automatic test_stats();
      nRST = 1'b1; cycle(); nRST = 1'b0; idle(); en = 1'b0; #1;
      n_cmp++; if (stat_lookups !== 32'd0) begin n_err++; $display("FAIL stat_rst: got %0d want 0", stat_lookups); end
      for (int i = 0; i < 8; i++) begin
         // en on for cycles 0,2,3,5,7 ; mispredict flagged on 2,5 (counted) and 4 (en low)
         en = (i == 0 || i == 2 || i == 3 || i == 5 || i == 7);
         upd_valid = (i == 2 || i == 4 || i == 5);
         upd_mispredict = upd_valid;
         upd_pc = 32'h100; upd_taken = 1'b0; upd_target = 32'h0;
         cycle();
      end
      idle(); en = 1'b0; #1;
      n_cmp++; if (stat_lookups !== 32'd5) begin n_err++; $display("FAIL stat_lookups: got %0d want 5", stat_lookups); end
      n_cmp++; if (stat_mispredicts !== 32'd2) begin n_err++; $display("FAIL stat_mispredicts: got %0d want 2", stat_mispredicts); end
      idle();
   endtask
`endif

   initial begin
      lookup_pc = '0; upd_pc = '0; upd_target = '0;
      test_reset();
      test_alloc();
      test_counter();
      test_miss_not_taken();
      test_conflict();
      test_hold_en();
      test_inv();
`ifdef BTB_STATS_EN
      test_stats();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL be decided as: one clock; reset is synchronous and active-high.
REQ-002 SHALL expose parameter ENTRIES, default 16, number of direct-mapped entries; power of two, range 2..256.
REQ-003 SHALL expose parameter ALLOC_CTR, default 2'b10 (WEAK_T), counter state written on allocation.
REQ-004 SHALL have ports (name direction width meaning):
- CLK  in  1  clock, all state on rising edge.
- nRST  in  1  synchronous active-high reset; name kept per codebase port naming.
- en  in  1  pipeline enable (ihit and not halted); gates all state updates.
- inv  in  1  invalidate all entries.
- lookup_pc  in  32  fetch-stage PC.
- pred_hit  out  1  valid entry with matching tag.
- pred_taken  out  1  predict taken.
- pred_target  out  32  predicted next PC.
- upd_valid  in  1  resolved branch/bne present in memory stage.
- upd_pc  in  32  PC of resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  32  actual branch address (baddr).
- upd_mispredict  in  1  prediction carried with the branch was wrong.

Function
REQ-005 SHALL derive IDX = log2(ENTRIES); index = pc[IDX+1:2]; tag = pc[31:IDX+2].
REQ-006 SHALL hold per entry: valid, tag, 32-bit target, 2-bit counter STRONG_NT(00), WEAK_NT(01), WEAK_T(10), STRONG_T(11).
REQ-007 SHALL compute lookup outputs combinationally from registered state, zero-cycle latency.
REQ-008 SHALL drive pred_hit = valid & tag match; pred_taken = pred_hit & ctr[1]; pred_target = stored target when pred_taken, else lookup_pc + 4.
REQ-009 SHALL, on en & upd_valid & hit at upd_pc, increment counter if upd_taken else decrement, saturating at STRONG_T/STRONG_NT; target overwritten only when upd_taken.
REQ-010 SHALL, on en & upd_valid & miss with upd_taken, allocate: valid=1, tag, target=upd_target, counter=ALLOC_CTR, replacing any resident entry.
REQ-011 SHALL NOT allocate on a miss with upd_taken=0.
REQ-012 SHALL, on lookup and update to the same index in one cycle, return pre-update contents; new contents visible next cycle.
REQ-013 SHALL, with en=0, hold all state; lookup outputs stay live.
REQ-014 SHALL, on en & inv, clear every valid bit in one cycle; inv dominates a simultaneous update (update dropped).
REQ-015 SHALL treat upd_mispredict as informational only (no state effect) unless BTB_STATS_EN is defined.

Reset
REQ-016 SHALL, on nRST high at a clock edge, clear all valid bits, set counters to WEAK_NT, targets and tags to 0, statistics to 0, independent of en.
REQ-017 SHALL give reset priority over inv and updates; during reset pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.

Configuration
REQ-018 SHALL, with BTB_STATS_EN defined, add outputs stat_lookups (32) and stat_mispredicts (32).
REQ-019 SHALL increment stat_lookups each en cycle, stat_mispredicts each en & upd_valid & upd_mispredict cycle; both saturate at 32'hFFFFFFFF.
REQ-020 SHALL, without BTB_STATS_EN, omit those ports and counters entirely; all other behaviour identical.

Structure
REQ-021 SHALL place word_t and the btb_ctr_t enum in cpu_types_pkg.
REQ-022 SHALL implement the 2-bit saturating counter as sub-module sat_counter2 (inputs cur, taken; output next), one per update path.
REQ-023 SHALL elaborate-fail if ENTRIES is not a power of two.

Verification
REQ-024 SHALL cover: reset, then lookup_pc=32'h40 -> pred_hit=0, pred_target=32'h44.
REQ-025 SHALL cover: update pc=32'h40 taken target=32'h80 -> next cycle lookup 32'h40 gives hit=1, taken=1, target=32'h80.
REQ-026 SHALL cover: three not-taken updates at 32'h40 after allocation -> counter 10->01->00->00, pred_taken=0, pred_target=32'h44.
REQ-027 SHALL cover (ENTRIES=16): allocate 32'h40, then taken update at 32'h80 (same index) -> lookup 32'h40 misses, 32'h80 hits.
REQ-028 SHALL cover: same-cycle lookup and allocate at 32'h40 -> miss that cycle, hit next; inv with update -> all entries miss next cycle.
REQ-029 SHALL cover (BTB_STATS_EN): 5 en cycles, 2 with upd_valid & upd_mispredict -> stat_lookups=5, stat_mispredicts=2; en=0 cycles not counted.
